logic_unit_scheduler: RTL and testbench

//  Shares one 74181-style logic_unit (s/a/b -> f, 4-bit, combinational) between NUM_REQ requesters.

---
 rtl/logic_unit_pkg.sv | 31 +++
 rtl/logic_unit_scheduler_rr_arbiter.sv | 35 +++
 rtl/logic_unit_scheduler.sv | 146 ++++++++++++++
 tb/tb_logic_unit_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit scheduler: FSM states, datapath width
// and the named 74181-style function select codes.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } lus_state_t;

  localparam int LU_W = 4;

  // Function select codes; the scheduler forwards these untouched.
  localparam logic [3:0] LU_NOT_A      = 4'b0000; // ~A
  localparam logic [3:0] LU_NOR        = 4'b0001; // ~(A|B)
  localparam logic [3:0] LU_NOTA_AND_B = 4'b0010; // ~A&B
  localparam logic [3:0] LU_ZERO       = 4'b0011; // 0
  localparam logic [3:0] LU_NAND       = 4'b0100; // ~(A&B)
  localparam logic [3:0] LU_NOT_B      = 4'b0101; // ~B
  localparam logic [3:0] LU_XOR        = 4'b0110; // A^B
  localparam logic [3:0] LU_A_AND_NOTB = 4'b0111; // A&~B
  localparam logic [3:0] LU_NOTA_OR_B  = 4'b1000; // ~A|B
  localparam logic [3:0] LU_XNOR       = 4'b1001; // ~(A^B)
  localparam logic [3:0] LU_B          = 4'b1010; // B
  localparam logic [3:0] LU_AND        = 4'b1011; // A&B
  localparam logic [3:0] LU_ONES       = 4'b1100; // all ones
  localparam logic [3:0] LU_A_OR_NOTB  = 4'b1101; // A|~B
  localparam logic [3:0] LU_OR         = 4'b1110; // A|B
  localparam logic [3:0] LU_A          = 4'b1111; // A

endpackage

// File: rtl/logic_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, ascending
// with wrap-around, and returns a one-hot grant plus its index. The pointer
// register is owned by the instantiating block.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // First requester at or after ptr (modulo N) wins; no request gives no grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = IDX_W'((int'(ptr) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        gnt[idx_s]   = 1'b1;
        gnt_idx      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Shares one combinational 4-bit logic unit between NUM_REQ requesters.
// A round-robin winner is accepted in IDLE, its operands are registered onto
// the lu_* bus for one cycle (EXEC), the result is captured and presented on
// the response channel (RESP) until accepted. One operation in flight.
module logic_unit_scheduler
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_s,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [LU_W-1:0]          lu_s,
  output logic [WIDTH-1:0]         lu_a,
  output logic [WIDTH-1:0]         lu_b,
  input  logic [WIDTH-1:0]         lu_f,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_f,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  lus_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [LU_W-1:0]  lu_s_q, lu_s_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_f_q, resp_f_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               accept_s;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Grants are only offered while idle; elsewhere every requester is held off.
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      req_ready = gnt_s;
      accept_s  = |gnt_s;
    end else begin
      req_ready = '0;
      accept_s  = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE -> EXEC -> RESP -> IDLE cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lu_s_d     = lu_s_q;
    lu_a_d     = lu_a_q;
    lu_b_d     = lu_b_q;
    resp_id_d  = resp_id_q;
    resp_f_d   = resp_f_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          lu_s_d    = req_s[int'(gnt_idx_s)*4 +: 4];
          lu_a_d    = req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
          lu_b_d    = req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];
          resp_id_d = gnt_idx_s;
          // Advance past the winner so it becomes lowest priority next time.
          if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx_s + ID_W'(1);
          end
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        resp_f_d = lu_f;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lu_s_q     <= '0;
      lu_a_q     <= '0;
      lu_b_q     <= '0;
      resp_id_q  <= '0;
      resp_f_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lu_s_q     <= lu_s_d;
      lu_a_q     <= lu_a_d;
      lu_b_q     <= lu_b_d;
      resp_id_q  <= resp_id_d;
      resp_f_q   <= resp_f_d;
      op_count_q <= op_count_d;
    end
  end

  assign lu_s       = lu_s_q;
  assign lu_a       = lu_a_q;
  assign lu_b       = lu_b_q;
  assign resp_id    = resp_id_q;
  assign resp_f     = resp_f_q;
  assign op_count   = op_count_q;
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Scoreboard bench for logic_unit_scheduler: a behavioural model predicts
// grants, timing and results; a monitor pops expectations on each response.
module tb_logic_unit_scheduler;
  import logic_unit_pkg::*;

  localparam int NR = 3;
  localparam int W  = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(NR);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*4-1:0] req_s;
  logic [NR*W-1:0] req_a, req_b;
  logic [3:0]      lu_s;
  logic [W-1:0]    lu_a, lu_b, lu_f;
  logic            resp_valid, resp_ready, busy;
  logic [IW-1:0]   resp_id;
  logic [W-1:0]    resp_f;
  logic [CW-1:0]   op_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         id;
    logic [3:0] f;
  } exp_t;
  exp_t exp_q[$];

  // model state: stage 0 idle, 1 executing, 2 responding
  int         m_stage, m_ptr, m_count;
  logic [3:0] m_lu_s, m_lu_a, m_lu_b;
  logic [3:0] last_f;
  int         last_id;

  always #5 clk = ~clk;

  logic_unit_scheduler #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_a(req_a), .req_b(req_b), .lu_s(lu_s), .lu_a(lu_a),
    .lu_b(lu_b), .lu_f(lu_f), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_f(resp_f), .busy(busy), .op_count(op_count)
  );

  function automatic logic [3:0] lu_ref(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      LU_NOT_A:      return ~a;
      LU_NOR:        return ~(a | b);
      LU_NOTA_AND_B: return ~a & b;
      LU_ZERO:       return 4'b0000;
      LU_NAND:       return ~(a & b);
      LU_NOT_B:      return ~b;
      LU_XOR:        return a ^ b;
      LU_A_AND_NOTB: return a & ~b;
      LU_NOTA_OR_B:  return ~a | b;
      LU_XNOR:       return ~(a ^ b);
      LU_B:          return b;
      LU_AND:        return a & b;
      LU_ONES:       return 4'b1111;
      LU_A_OR_NOTB:  return a | ~b;
      LU_OR:         return a | b;
      default:       return a;
    endcase
  endfunction

  // external logic unit stand-in
  assign lu_f = lu_ref(lu_s, lu_a, lu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT at %0t", nm, $time);
  endtask

  // Behavioural model: predicts what the next clock edge does from current inputs.
  always @(negedge clk) begin
    int w;
    int idx;
    exp_t e;
    if (!rst_n) begin
      m_stage = 0; m_ptr = 0; m_count = 0;
      m_lu_s = 4'd0; m_lu_a = 4'd0; m_lu_b = 4'd0;
      exp_q.delete();
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, m_stage != 0});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_stage == 2});
      chk("op_count", 32'(op_count), 32'(m_count));
      chk("lu_s", 32'(lu_s), 32'(m_lu_s));
      chk("lu_a", 32'(lu_a), 32'(m_lu_a));
      chk("lu_b", 32'(lu_b), 32'(m_lu_b));
      if (m_stage == 2 && !resp_ready && exp_q.size() > 0) begin
        chk("hold_id", 32'(resp_id), 32'(exp_q[0].id));
        chk("hold_f", 32'(resp_f), 32'(exp_q[0].f));
      end
      if (m_stage == 0) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (w < 0 && req_valid[idx]) w = idx;
        end
        chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w >= 0) begin
          m_lu_s = req_s[4*w +: 4];
          m_lu_a = req_a[W*w +: W];
          m_lu_b = req_b[W*w +: W];
          e.id = w;
          e.f  = lu_ref(m_lu_s, m_lu_a, m_lu_b);
          exp_q.push_back(e);
          m_ptr   = (w + 1) % NR;
          m_stage = 1;
        end
      end else if (m_stage == 1) begin
        chk("req_ready_exec", 32'(req_ready), 32'd0);
        m_stage = 2;
      end else begin
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        if (resp_ready) begin
          m_count = (m_count + 1) % (1 << CW);
          m_stage = 0;
        end
      end
    end
  end

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: id %0d f %0h with nothing expected", resp_id, resp_f);
      end else begin
        e = exp_q.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_f", 32'(resp_f), 32'(e.f));
        last_f  = resp_f;
        last_id = int'(resp_id);
      end
    end
  end

  task automatic do_op(input int id, input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] b, input logic rr);
    bit ok;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_s[4*id +: 4] = s;
    req_a[W*id +: W] = a;
    req_b[W*id +: W] = b;
    resp_ready = rr;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    if (!ok) timeout("grant");
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) timeout("done");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] sweep_tab [16];

  initial begin
    bit ok;
    sweep_tab = '{4'b0101, 4'b0001, 4'b0100, 4'b0000, 4'b0111, 4'b0011, 4'b0110, 4'b0010,
                  4'b1101, 4'b1001, 4'b1100, 4'b1000, 4'b1111, 4'b1011, 4'b1110, 4'b1010};
    rst_n = 1'b0; req_valid = '0; req_s = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    last_f = 4'd0; last_id = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_f", 32'(resp_f), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);

    // single XOR operation from requester 0
    do_op(0, 4'b0110, 4'b1010, 4'b0110, 1'b1);
    wait_done();
    chk("t1_f", 32'(last_f), 32'hc);
    chk("t1_id", 32'(last_id), 32'd0);
    chk("t1_cnt", 32'(op_count), 32'd1);

    // two simultaneous requesters straight out of reset
    pulse_reset();
    @(posedge clk); #1;
    req_valid = 3'b011; resp_ready = 1'b1;
    req_s[3:0] = 4'b1110; req_a[3:0] = 4'b0011; req_b[3:0] = 4'b0101;
    req_s[7:4] = 4'b1011; req_a[7:4] = 4'b0111; req_b[7:4] = 4'b1100;
    for (int r = 0; r < 2; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (req_ready != '0) ok = 1'b1;
      end
      if (!ok) timeout("dual_grant");
      @(posedge clk); #1;
      req_valid = req_valid & ~req_ready;
    end
    req_valid = '0;
    wait_done();
    chk("t2_last_id", 32'(last_id), 32'd1);

    // back-pressure on the response channel
    do_op(1, 4'b0111, 4'b1101, 4'b0110, 1'b0);
    repeat (7) @(negedge clk);
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_done();

    // every select code with a=1010 b=1100
    for (int s = 0; s < 16; s++) begin
      do_op(s % NR, 4'(s), 4'b1010, 4'b1100, 1'b1);
      wait_done();
      chk("sweep", 32'(last_f), 32'(sweep_tab[s]));
    end

    // reset while an operation is executing
    do_op(2, 4'b1111, 4'b0101, 4'b0000, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_cnt", 32'(op_count), 32'd0);

    // randomized traffic, including counter wrap and rare resets
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req_valid  = NR'($urandom);
      req_s      = (NR*4)'($urandom);
      req_a      = (NR*W)'($urandom);
      req_b      = (NR*W)'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0; resp_ready = 1'b1;
    wait_done();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
